leddc_scan_sched: RTL and testbench
===================================

Name: leddc_scan_sched

Overview:
- Scan/PWM scheduler for the LEDDC display path. Runs in the GCK domain.
- Sequences the 32 scanlines of a frame against Vsync and generates the 16-bit PWM reference count.
- Prefetches the next scanline's 16 grayscale words from the ping-pong frame SRAM into the shadow registers.
- Swaps the display bank at frame boundaries once the DCK-side writer reports a full frame (writer handshake already synchronised into GCK).

Parameters:
- N_CH, 16, channels per scanline (OUT width).
- N_LINE, 32, scanlines per frame.
- CNT_W, 16, PWM counter width; a line lasts 2^CNT_W GCK cycles.
- PREF_START, 16'hFFC0, pwm_cnt value at which the next-line prefetch starts. Must be ≤ 2^CNT_W − N_CH − RD_LAT − 2.
- RD_LAT, 1, SRAM read latency in cycles.

Ports:
- GCK, in, 1, scheduler clock.
- rst, in, 1, synchronous active-low reset.
- Vsync, in, 1, scanline enable from the panel timing.
- buf_ready, in, 1, one-cycle pulse: back bank fully written.
- sram_rd_en, out, 1, SRAM read strobe.
- sram_addr, out, 10, read address {bank, line[4:0], ch[3:0]}.
- shd_we, out, 1, shadow register write; asserted RD_LAT cycles after sram_rd_en.
- shd_idx, out, 4, shadow register index for shd_we.
- line_load, out, 1, one-cycle pulse: copy shadow → active gray registers.
- pwm_en, out, 1, high while pwm_cnt is valid for comparison.
- pwm_cnt, out, 16, PWM reference count.
- scan_line, out, 5, line currently displayed.
- bank_sel, out, 1, bank currently displayed.
- bank_free, out, 1, one-cycle pulse: old display bank released to the writer.
- underrun, out, 1, sticky: Vsync rise with no valid preload.
- overrun, out, 1, sticky: buf_ready while a swap is already pending.

Behaviour:
- Reset (rst=0 at a GCK edge, including mid-operation):
  - state=IDLE; all outputs 0; swap_pending=0; prefetch sequencer cleared; vs_q=0.
- General rules:
  - All outputs are registered.
  - vs_rise is detected at an edge where Vsync=1 and vs_q=0.
- FSM states: IDLE, PRELOAD, WAIT_VS, RUN, GAP.
- IDLE:
  - On buf_ready: toggle bank_sel, go to PRELOAD. No bank_free on this first swap.
  - On vs_rise: set underrun, stay in IDLE.
- PRELOAD:
  - Issues N_CH reads on consecutive cycles: ch 0..15, line 0, new bank.
  - Goes to WAIT_VS after the last shd_we.
- WAIT_VS:
  - On vs_rise at edge T: after T, line_load=1 for one cycle, pwm_en=1, pwm_cnt=0, scan_line=0. Go to RUN.
- RUN:
  - pwm_cnt increments every cycle. pwm_en stays high exactly 2^CNT_W cycles (counts 0..65535).
  - After that, pwm_en=0 and pwm_cnt holds 65535.
  - When pwm_cnt==PREF_START, a 16-read prefetch starts for the next line (scan_line+1, same bank).
  - If scan_line==N_LINE−1, the next line is 0. Its bank is the toggled bank if swap_pending, else the same bank (repeat frame). On a swap, bank_free pulses the cycle the first prefetch read issues, and swap_pending clears.
  - Vsync=0 → GAP.
  - Vsync falling before the count completes: pwm_en drops the next cycle and the line is abandoned. Any prefetch in flight still completes.
- GAP:
  - pwm_en=0.
  - On vs_rise: line_load pulse, scan_line advances (wraps 31→0), bank_sel takes the prefetched bank, pwm_cnt=0, pwm_en=1 → RUN.
  - If vs_rise occurs while the prefetch is incomplete: underrun set, line_load is delayed until the last shd_we, and pwm_en rises with it.
- buf_ready outside IDLE:
  - Sets swap_pending.
  - If swap_pending is already 1: set overrun, pending stays 1.
- Timing/width rules:
  - Prefetch reads are back-to-back.
  - shd_idx equals the ch field of the matching read, delayed RD_LAT cycles.
  - No read is issued while pwm_cnt < PREF_START.

Test Plan:
- Reset, then buf_ready, then Vsync rise → bank_sel=1; reads at 0x200..0x20F; 16 shd_we with idx 0..15; line_load pulse; pwm_en high 65536 cycles; pwm_cnt ends at 0xFFFF.
- Full frame with 32 Vsync pulses and no further buf_ready → scan_line 0..31 then back to 0; second frame reads bank 1 again; bank_free never pulses.
- buf_ready during line 10, then run to end of frame → line-0 prefetch at 0x000..0x00F; bank_free pulses once; bank_sel=0 after the next vs_rise.
- Two buf_ready pulses within one frame → overrun=1; exactly one swap at the frame boundary.
- Vsync rise before any buf_ready → underrun=1, pwm_en stays 0. Vsync dropped at pwm_cnt=0x1000 → pwm_en=0 next cycle, prefetch not issued.
- rst=0 during a RUN prefetch (pwm_cnt=0xFFC5) → next cycle all outputs 0 and state IDLE; a later buf_ready restarts with bank_sel=1.

Source files
------------

// File: rtl/leddc_scan_sched.sv
// Scan/PWM scheduler: sequences scanlines against Vsync, runs the PWM reference count,
// prefetches the next line from the ping-pong SRAM into shadow registers and swaps banks per frame.
module leddc_scan_sched #(
    parameter int          N_CH       = 16,
    parameter int          N_LINE     = 32,
    parameter int          CNT_W      = 16,
    parameter int unsigned PREF_START = 32'hFFC0,
    parameter int          RD_LAT     = 1,
    localparam int         CW         = $clog2(N_CH),
    localparam int         LW         = $clog2(N_LINE),
    localparam int         AW         = 1 + LW + CW
) (
    input  logic             GCK,
    input  logic             rst,
    input  logic             Vsync,
    input  logic             buf_ready,
    output logic             sram_rd_en,
    output logic [AW-1:0]    sram_addr,
    output logic             shd_we,
    output logic [CW-1:0]    shd_idx,
    output logic             line_load,
    output logic             pwm_en,
    output logic [CNT_W-1:0] pwm_cnt,
    output logic [LW-1:0]    scan_line,
    output logic             bank_sel,
    output logic             bank_free,
    output logic             underrun,
    output logic             overrun
);

    typedef enum logic [2:0] {IDLE, PRELOAD, WAIT_VS, RUN, GAP} state_t;

    state_t                     state_q, state_d;
    logic                       vs_q, vs_d;
    logic                       sram_rd_en_q, sram_rd_en_d;
    logic [AW-1:0]              sram_addr_q, sram_addr_d;
    logic [RD_LAT-1:0]          we_pipe_q, we_pipe_d;
    logic [RD_LAT-1:0][CW-1:0]  idx_pipe_q, idx_pipe_d;
    logic                       line_load_q, line_load_d;
    logic                       pwm_en_q, pwm_en_d;
    logic [CNT_W-1:0]           pwm_cnt_q, pwm_cnt_d;
    logic [LW-1:0]              scan_line_q, scan_line_d;
    logic                       bank_sel_q, bank_sel_d;
    logic                       bank_free_q, bank_free_d;
    logic                       underrun_q, underrun_d;
    logic                       overrun_q, overrun_d;
    logic                       swap_pending_q, swap_pending_d;
    logic                       pf_act_q, pf_act_d;
    logic [CW-1:0]              pf_ch_q, pf_ch_d;
    logic [LW-1:0]              pf_line_q, pf_line_d;
    logic                       pf_bank_q, pf_bank_d;
    logic                       pf_go_q, pf_go_d;
    logic                       pf_rdy_q, pf_rdy_d;
    logic                       ld_pend_q, ld_pend_d;

    logic                       vs_rise, last_we, pf_ready, start_pre, start_nxt, nxt_wrap, do_load;
    logic [LW-1:0]              nxt_line;

    always_comb begin
        state_d        = state_q;
        vs_d           = Vsync;
        sram_rd_en_d   = 1'b0;
        sram_addr_d    = sram_addr_q;
        we_pipe_d      = we_pipe_q;
        idx_pipe_d     = idx_pipe_q;
        line_load_d    = 1'b0;
        pwm_en_d       = pwm_en_q;
        pwm_cnt_d      = pwm_cnt_q;
        scan_line_d    = scan_line_q;
        bank_sel_d     = bank_sel_q;
        bank_free_d    = 1'b0;
        underrun_d     = underrun_q;
        overrun_d      = overrun_q;
        swap_pending_d = swap_pending_q;
        pf_act_d       = pf_act_q;
        pf_ch_d        = pf_ch_q;
        pf_line_d      = pf_line_q;
        pf_bank_d      = pf_bank_q;
        pf_go_d        = pf_go_q;
        pf_rdy_d       = pf_rdy_q;
        ld_pend_d      = ld_pend_q;
        start_pre      = 1'b0;
        start_nxt      = 1'b0;
        do_load        = 1'b0;

        vs_rise  = Vsync && !vs_q;
        last_we  = we_pipe_q[RD_LAT-1] && (idx_pipe_q[RD_LAT-1] == CW'(N_CH - 1));
        pf_ready = pf_rdy_q || last_we;
        nxt_wrap = (scan_line_q == LW'(N_LINE - 1));
        nxt_line = nxt_wrap ? '0 : scan_line_q + 1'b1;

        we_pipe_d[0]  = sram_rd_en_q;
        idx_pipe_d[0] = sram_addr_q[CW-1:0];
        for (int i = 1; i < RD_LAT; i++) begin
            we_pipe_d[i]  = we_pipe_q[i-1];
            idx_pipe_d[i] = idx_pipe_q[i-1];
        end

        if (last_we) pf_rdy_d = 1'b1;

        case (state_q)
            IDLE: begin
                if (buf_ready) begin
                    bank_sel_d = ~bank_sel_q;
                    start_pre  = 1'b1;
                    state_d    = PRELOAD;
                end else if (vs_rise) begin
                    underrun_d = 1'b1;
                end
            end
            PRELOAD: if (last_we) state_d = WAIT_VS;
            WAIT_VS: if (vs_rise) do_load = 1'b1;
            RUN: begin
                if (!Vsync) begin
                    pwm_en_d = 1'b0;
                    state_d  = GAP;
                end else if (pwm_en_q) begin
                    if (&pwm_cnt_q) pwm_en_d  = 1'b0;
                    else            pwm_cnt_d = pwm_cnt_q + 1'b1;
                    if (32'(pwm_cnt_q) == PREF_START && !pf_go_q) start_nxt = 1'b1;
                end
            end
            GAP: begin
                if (vs_rise || ld_pend_q) begin
                    if (pf_ready) begin
                        do_load   = 1'b1;
                        ld_pend_d = 1'b0;
                    end else begin
                        // Late line: hold the load until the shadow registers are complete.
                        ld_pend_d = 1'b1;
                        if (vs_rise) underrun_d = 1'b1;
                        if (!pf_go_q) start_nxt = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (do_load) begin
            line_load_d = 1'b1;
            pwm_en_d    = 1'b1;
            pwm_cnt_d   = '0;
            scan_line_d = pf_line_q;
            bank_sel_d  = pf_bank_q;
            pf_rdy_d    = 1'b0;
            pf_go_d     = 1'b0;
            state_d     = RUN;
        end

        if (start_pre || start_nxt) begin
            pf_line_d = start_pre ? '0 : nxt_line;
            pf_bank_d = (start_pre || (nxt_wrap && swap_pending_q)) ? ~bank_sel_q : bank_sel_q;
            if (start_nxt && nxt_wrap && swap_pending_q) begin
                bank_free_d    = 1'b1;
                swap_pending_d = 1'b0;
            end
            pf_act_d     = 1'b1;
            pf_ch_d      = CW'(1);
            pf_go_d      = 1'b1;
            sram_rd_en_d = 1'b1;
            sram_addr_d  = {pf_bank_d, pf_line_d, {CW{1'b0}}};
        end else if (pf_act_q) begin
            sram_rd_en_d = 1'b1;
            sram_addr_d  = {pf_bank_q, pf_line_q, pf_ch_q};
            pf_ch_d      = pf_ch_q + 1'b1;
            if (pf_ch_q == CW'(N_CH - 1)) pf_act_d = 1'b0;
        end

        // Evaluated after the swap so a coincident buf_ready re-arms the next frame.
        if (buf_ready && state_q != IDLE) begin
            if (swap_pending_q) overrun_d = 1'b1;
            swap_pending_d = 1'b1;
        end
    end

    always_ff @(posedge GCK) begin
        if (!rst) begin
            state_q        <= IDLE;
            vs_q           <= 1'b0;
            sram_rd_en_q   <= 1'b0;
            sram_addr_q    <= '0;
            we_pipe_q      <= '0;
            idx_pipe_q     <= '0;
            line_load_q    <= 1'b0;
            pwm_en_q       <= 1'b0;
            pwm_cnt_q      <= '0;
            scan_line_q    <= '0;
            bank_sel_q     <= 1'b0;
            bank_free_q    <= 1'b0;
            underrun_q     <= 1'b0;
            overrun_q      <= 1'b0;
            swap_pending_q <= 1'b0;
            pf_act_q       <= 1'b0;
            pf_ch_q        <= '0;
            pf_line_q      <= '0;
            pf_bank_q      <= 1'b0;
            pf_go_q        <= 1'b0;
            pf_rdy_q       <= 1'b0;
            ld_pend_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            vs_q           <= vs_d;
            sram_rd_en_q   <= sram_rd_en_d;
            sram_addr_q    <= sram_addr_d;
            we_pipe_q      <= we_pipe_d;
            idx_pipe_q     <= idx_pipe_d;
            line_load_q    <= line_load_d;
            pwm_en_q       <= pwm_en_d;
            pwm_cnt_q      <= pwm_cnt_d;
            scan_line_q    <= scan_line_d;
            bank_sel_q     <= bank_sel_d;
            bank_free_q    <= bank_free_d;
            underrun_q     <= underrun_d;
            overrun_q      <= overrun_d;
            swap_pending_q <= swap_pending_d;
            pf_act_q       <= pf_act_d;
            pf_ch_q        <= pf_ch_d;
            pf_line_q      <= pf_line_d;
            pf_bank_q      <= pf_bank_d;
            pf_go_q        <= pf_go_d;
            pf_rdy_q       <= pf_rdy_d;
            ld_pend_q      <= ld_pend_d;
        end
    end

    assign sram_rd_en = sram_rd_en_q;
    assign sram_addr  = sram_addr_q;
    assign shd_we     = we_pipe_q[RD_LAT-1];
    assign shd_idx    = idx_pipe_q[RD_LAT-1];
    assign line_load  = line_load_q;
    assign pwm_en     = pwm_en_q;
    assign pwm_cnt    = pwm_cnt_q;
    assign scan_line  = scan_line_q;
    assign bank_sel   = bank_sel_q;
    assign bank_free  = bank_free_q;
    assign underrun   = underrun_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_leddc_scan_sched.sv
// Directed bench for leddc_scan_sched with a shortened line (CNT_W=8, prefetch at 0xC0).
module tb_leddc_scan_sched;

    logic       GCK = 1'b0;
    logic       rst = 1'b0;
    logic       Vsync = 1'b0;
    logic       buf_ready = 1'b0;
    logic       sram_rd_en;
    logic [9:0] sram_addr;
    logic       shd_we;
    logic [3:0] shd_idx;
    logic       line_load;
    logic       pwm_en;
    logic [7:0] pwm_cnt;
    logic [4:0] scan_line;
    logic       bank_sel;
    logic       bank_free;
    logic       underrun;
    logic       overrun;

    leddc_scan_sched #(
        .N_CH(16), .N_LINE(32), .CNT_W(8), .PREF_START(32'hC0), .RD_LAT(1)
    ) dut (
        .GCK(GCK), .rst(rst), .Vsync(Vsync), .buf_ready(buf_ready),
        .sram_rd_en(sram_rd_en), .sram_addr(sram_addr), .shd_we(shd_we), .shd_idx(shd_idx),
        .line_load(line_load), .pwm_en(pwm_en), .pwm_cnt(pwm_cnt), .scan_line(scan_line),
        .bank_sel(bank_sel), .bank_free(bank_free), .underrun(underrun), .overrun(overrun)
    );

    always #5 GCK = ~GCK;

    int vec_cnt = 0;
    int err_cnt = 0;

    logic [9:0] rd_log [4096];
    logic [3:0] we_log [4096];
    int rd_n = 0, we_n = 0, bf_n = 0, en_n = 0, bad_rd = 0;

    always @(negedge GCK) begin
        if (sram_rd_en === 1'b1 && rd_n < 4096) begin
            rd_log[rd_n] = sram_addr;
            rd_n = rd_n + 1;
        end
        if (shd_we === 1'b1 && we_n < 4096) begin
            we_log[we_n] = shd_idx;
            we_n = we_n + 1;
        end
        if (bank_free === 1'b1) bf_n = bf_n + 1;
        if (pwm_en === 1'b1) en_n = en_n + 1;
        if (sram_rd_en === 1'b1 && pwm_en === 1'b1 && pwm_cnt < 8'hC0) bad_rd = bad_rd + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge GCK);
            #1;
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_rd_en"}, sram_rd_en, 0);
        chk({tag, "_addr"}, sram_addr, 0);
        chk({tag, "_shd_we"}, {shd_we, shd_idx}, 0);
        chk({tag, "_line_load"}, line_load, 0);
        chk({tag, "_pwm"}, {pwm_en, pwm_cnt}, 0);
        chk({tag, "_scan_line"}, scan_line, 0);
        chk({tag, "_bank"}, {bank_sel, bank_free}, 0);
        chk({tag, "_flags"}, {underrun, overrun}, 0);
    endtask

    task automatic run_line(input bit br, output logic [4:0] ln, output logic bk, output logic ll,
                            output logic [7:0] c0, output int rds, output logic [9:0] a0,
                            output int en, output logic [7:0] cend);
        int s, e0, n;
        s = rd_n;
        e0 = en_n;
        Vsync = 1'b1;
        n = 0;
        do begin
            tick();
            n++;
        end while (!pwm_en && n < 100);
        chk("line_start", pwm_en, 1);
        ln = scan_line;
        bk = bank_sel;
        ll = line_load;
        c0 = pwm_cnt;
        if (br) begin
            tick(5);
            buf_ready = 1'b1;
            tick();
            buf_ready = 1'b0;
        end
        n = 0;
        while (pwm_en && n < 1000) begin
            tick();
            n++;
        end
        chk("line_end", pwm_en, 0);
        cend = pwm_cnt;
        en = en_n - e0;
        rds = rd_n - s;
        a0 = rd_log[s];
        Vsync = 1'b0;
        tick(2);
    endtask

    task automatic run_frame(input logic exp_bk, input int br_a, input int br_b, input logic nxt_bk);
        logic [4:0] ln;
        logic       bk, ll;
        logic [7:0] c0, cend;
        logic [9:0] a0;
        int         rds, en;
        for (int i = 0; i < 32; i++) begin
            run_line(i == br_a || i == br_b, ln, bk, ll, c0, rds, a0, en, cend);
            chk("scan_line", ln, i);
            chk("bank_sel", bk, exp_bk);
            chk("line_load_cnt0", {ll, c0}, 9'h100);
            chk("pf_reads", rds, 16);
            chk("pf_addr", a0, {(i == 31) ? nxt_bk : exp_bk, 5'((i + 1) % 32), 4'h0});
            chk("pwm_en_len", en, 256);
            chk("pwm_cnt_end", cend, 8'hFF);
        end
    endtask

    initial begin
        int s, ws, bf0, n, rds, en;
        logic [4:0] ln;
        logic       bk, ll;
        logic [7:0] c0, cend;
        logic [9:0] a0;

        tick(3);
        check_zero("reset");

        // Vsync before any buffer: underrun, nothing displayed
        rst = 1'b1;
        tick();
        s = rd_n;
        Vsync = 1'b1;
        tick(2);
        chk("idle_underrun", underrun, 1);
        chk("idle_pwm_en", pwm_en, 0);
        chk("idle_no_reads", rd_n - s, 0);
        Vsync = 1'b0;
        rst = 1'b0;
        tick();
        chk("reset_clears_underrun", underrun, 0);
        rst = 1'b1;
        tick(2);

        // First buffer: preload bank 1 line 0
        s = rd_n;
        ws = we_n;
        buf_ready = 1'b1;
        tick();
        buf_ready = 1'b0;
        chk("preload_bank", bank_sel, 1);
        tick(20);
        chk("preload_reads", rd_n - s, 16);
        chk("preload_we", we_n - ws, 16);
        for (int i = 0; i < 16; i++) begin
            chk("preload_addr", rd_log[s + i], 10'h200 + 10'(i));
            chk("preload_idx", we_log[ws + i], i);
        end

        bf0 = bf_n;
        run_frame(1'b1, -1, -1, 1'b1);
        chk("frame_a_bank_free", bf_n - bf0, 0);

        bf0 = bf_n;
        run_frame(1'b1, 10, -1, 1'b0);
        chk("frame_b_bank_free", bf_n - bf0, 1);
        chk("frame_b_overrun", overrun, 0);

        bf0 = bf_n;
        run_frame(1'b0, 1, 2, 1'b1);
        chk("frame_c_bank_free", bf_n - bf0, 1);
        chk("frame_c_overrun", overrun, 1);

        bf0 = bf_n;
        run_line(1'b0, ln, bk, ll, c0, rds, a0, en, cend);
        chk("frame_d_line", ln, 0);
        chk("frame_d_bank", bk, 1);
        chk("frame_d_pf_addr", a0, 10'h210);
        chk("frame_d_bank_free", bf_n - bf0, 0);

        // Line 1 abandoned at pwm_cnt 0x10
        s = rd_n;
        Vsync = 1'b1;
        n = 0;
        do begin
            tick();
            n++;
        end while (!pwm_en && n < 100);
        chk("drop_line", scan_line, 1);
        n = 0;
        while (pwm_cnt != 8'h10 && n < 100) begin
            tick();
            n++;
        end
        Vsync = 1'b0;
        tick();
        chk("drop_pwm_en", pwm_en, 0);
        tick(300);
        chk("drop_no_prefetch", rd_n - s, 0);
        chk("drop_underrun_pre", underrun, 0);

        // Vsync rise without a valid preload
        s = rd_n;
        Vsync = 1'b1;
        n = 0;
        do begin
            tick();
            n++;
        end while (!line_load && n < 100);
        chk("late_load_delay", n, 18);
        chk("late_pwm_en", {pwm_en, pwm_cnt}, 9'h100);
        chk("late_underrun", underrun, 1);
        chk("late_scan_line", scan_line, 2);
        chk("late_bank", bank_sel, 1);
        chk("late_reads", rd_n - s, 16);
        chk("late_addr", rd_log[s], 10'h220);

        // Reset while the line-3 prefetch is in flight
        n = 0;
        while (pwm_cnt != 8'hC5 && n < 400) begin
            tick();
            n++;
        end
        chk("inflight_rd_en", sram_rd_en, 1);
        rst = 1'b0;
        Vsync = 1'b0;
        tick();
        check_zero("midrun_reset");
        rst = 1'b1;
        tick(3);
        s = rd_n;
        buf_ready = 1'b1;
        tick();
        buf_ready = 1'b0;
        chk("restart_bank", bank_sel, 1);
        tick(20);
        chk("restart_reads", rd_n - s, 16);
        chk("restart_addr0", rd_log[s], 10'h200);
        chk("restart_addr15", rd_log[s + 15], 10'h20F);

        chk("no_read_before_pref", bad_rd, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
